ccip_line_reader: RTL
=====================

Name: ccip_line_reader

Overview:
- Host-memory read engine; complements the AFU's MMIO-triggered line writer.
- Reads num_lines consecutive 64-byte cache lines starting at a cache-line address, using CCI-P c0 RDLINE requests.
- Reorders out-of-order read responses and presents lines in ascending order on a valid/ready stream for AFU-internal consumers.
- Control comes from MMIO-decoded start/base/length registers in the AFU top.

Parameters:
MAX_OUTSTANDING, 8, reorder slots and max in-flight reads; power of two, 2..64
LEN_W, 16, width of line count and index

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle start pulse; sampled only in IDLE
base_addr  in  42  first cache-line address (t_ccip_clAddr)
num_lines  in  LEN_W  lines to read
busy  out  1  high in RUN
done  out  1  one-cycle pulse when last line accepted downstream
err_unexpected  out  1  sticky: response tag not PENDING
c0_req_valid  out  1  read request valid (eREQ_RDLINE_I, eVC_VA, eCL_LEN_1)
c0_req_addr  out  42  request cache-line address
c0_req_mdata  out  16  request tag; upper bits 0
c0_almost_full  in  1  CCI-P c0TxAlmFull
c0_rsp_valid  in  1  read response valid (rspValid with eRSP_RDLINE)
c0_rsp_mdata  in  16  returned tag
c0_rsp_data  in  512  returned line
out_valid  out  1  stream valid
out_data  out  512  line data
out_index  out  LEN_W  line index 0..num_lines-1
out_ready  in  1  consumer accept

Behaviour:
- Reset rst is asynchronous and active-high; clock is clk.
- Reset values: busy=0, done=0, err_unexpected=0, c0_req_valid=0, c0_req_addr=0, c0_req_mdata=0, out_valid=0, out_data=0, out_index=0. All slots FREE; counters zero; state IDLE.
- States:
  - IDLE: on start, latch base_addr/num_lines, clear issue_cnt, deliver_cnt and err_unexpected.
    - num_lines==0: done=1 next cycle, stay IDLE.
    - Otherwise go to RUN.
  - RUN: leave when deliver_cnt reaches num_lines. done pulses in that same registered update; back to IDLE.
- start in RUN is ignored.
- Slot states: FREE, PENDING, FILLED. slot = index mod MAX_OUTSTANDING.
- Issue (registered, one request per cycle max) when all of:
  - RUN
  - issue_cnt < num_lines
  - c0_almost_full == 0 in the current cycle
  - slot[issue_cnt] is FREE
- On issue, next cycle:
  - c0_req_valid=1, c0_req_addr = base + issue_cnt, modulo 2^42, wraps silently.
  - c0_req_mdata = slot number.
  - slot becomes PENDING; issue_cnt++.
- Otherwise c0_req_valid=0.
- Because slots are strictly in index order, at most MAX_OUTSTANDING lines are PENDING or FILLED.
- Responses cannot be back-pressured and are accepted every cycle. On c0_rsp_valid:
  - Tag slot PENDING: store data, slot becomes FILLED.
  - Otherwise, including any response arriving in IDLE: drop data and set err_unexpected.
  - Tag bits above the slot width are nonzero: also treated as unexpected.
- Output: out_valid is high iff RUN and slot[deliver_cnt] is FILLED. out_data and out_index come from that slot and deliver_cnt.
  - Values hold stable while out_valid && !out_ready.
  - On out_valid && out_ready: slot becomes FREE and deliver_cnt++.
  - That slot may be reissued no earlier than the following cycle.
- Same-cycle events are all legal:
  - response fill + delivery of a different slot + issue;
  - response fill and out_valid on the same slot. out_valid asserts the cycle after the fill; there is no bypass.
- Latency: minimum 1 cycle from response fill to out_valid.
- Reset mid-operation: all state is cleared immediately. Responses still in flight from before reset arrive in IDLE and set err_unexpected. Software clears it on the next start.

Test Plan:
- base=0x1000, num_lines=4, responses in order 2 cycles after each request, out_ready=1 → requests at 0x1000..0x1003 with mdata 0..3; out_index 0,1,2,3 in order; one done pulse; busy low after.
- MAX_OUTSTANDING=8, num_lines=8, responses returned in order 7,6,...,0 → no out_valid until tag 0 arrives; then 8 consecutive beats index 0..7 with correct data.
- num_lines=20, out_ready=0 → exactly 8 requests issued and stalled; raising out_ready → remaining 12 issued as slots free; 20 lines delivered in order.
- c0_almost_full held high for 10 cycles mid-transfer → no c0_req_valid during the hold; issuing resumes the cycle after it drops; no line lost.
- Edge cases:
  - num_lines=0 → done the cycle after start, no requests.
  - base=0x3FFFFFFFFFF, num_lines=2 → addresses 0x3FFFFFFFFFF, 0x0.
- Errors and reset:
  - Response with tag 5 while slot 5 is FREE → err_unexpected=1, no out_valid.
  - Assert rst with 3 reads outstanding, then return those responses → all outputs zero; err_unexpected=1; next start clears it.

Source files
------------

// File: rtl/ccip_line_reader.sv
// CCI-P c0 read engine: fetches num_lines consecutive cache lines starting at base_addr,
// reorders responses by tag and streams the lines out in ascending index order.
module ccip_line_reader #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int LEN_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [41:0]      base_addr,
  input  logic [LEN_W-1:0] num_lines,
  output logic             busy,
  output logic             done,
  output logic             err_unexpected,
  output logic             c0_req_valid,
  output logic [41:0]      c0_req_addr,
  output logic [15:0]      c0_req_mdata,
  input  logic             c0_almost_full,
  input  logic             c0_rsp_valid,
  input  logic [15:0]      c0_rsp_mdata,
  input  logic [511:0]     c0_rsp_data,
  output logic             out_valid,
  output logic [511:0]     out_data,
  output logic [LEN_W-1:0] out_index,
  input  logic             out_ready
);

  localparam int SLOT_W = $clog2(MAX_OUTSTANDING);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] SLOT_FREE    = 2'd0;
  localparam logic [1:0] SLOT_PENDING = 2'd1;
  localparam logic [1:0] SLOT_FILLED  = 2'd2;

  logic [0:0]       state;
  logic [41:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issue_cnt;
  logic [LEN_W-1:0] deliver_cnt;
  logic [1:0]       slot_st   [MAX_OUTSTANDING];
  logic [511:0]     slot_data [MAX_OUTSTANDING];

  logic [SLOT_W-1:0] issue_slot;
  logic [SLOT_W-1:0] deliver_slot;
  logic [SLOT_W-1:0] rsp_slot;
  logic              rsp_tag_ok;
  logic              rsp_fill;
  logic              rsp_bad;
  logic              do_issue;
  logic              do_deliver;
  logic              last_deliver;

  assign issue_slot   = issue_cnt[SLOT_W-1:0];
  assign deliver_slot = deliver_cnt[SLOT_W-1:0];
  assign rsp_slot     = c0_rsp_mdata[SLOT_W-1:0];

  // A tag with any bit set above the slot field can never have been issued.
  assign rsp_tag_ok = (c0_rsp_mdata >> SLOT_W) == 16'd0;
  assign rsp_fill   = c0_rsp_valid && (state == S_RUN) && rsp_tag_ok &&
                      (slot_st[rsp_slot] == SLOT_PENDING);
  assign rsp_bad    = c0_rsp_valid && !rsp_fill;

  assign do_issue = (state == S_RUN) && (issue_cnt < len_q) && !c0_almost_full &&
                    (slot_st[issue_slot] == SLOT_FREE);

  assign busy         = (state == S_RUN);
  assign out_valid    = (state == S_RUN) && (slot_st[deliver_slot] == SLOT_FILLED);
  assign out_data     = out_valid ? slot_data[deliver_slot] : '0;
  assign out_index    = deliver_cnt;
  assign do_deliver   = out_valid && out_ready;
  assign last_deliver = do_deliver && ((deliver_cnt + LEN_W'(1)) == len_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the slot transitions below touch distinct slots and never race.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      base_q         <= '0;
      len_q          <= '0;
      issue_cnt      <= '0;
      deliver_cnt    <= '0;
      done           <= 1'b0;
      err_unexpected <= 1'b0;
      c0_req_valid   <= 1'b0;
      c0_req_addr    <= '0;
      c0_req_mdata   <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) slot_st[i] <= SLOT_FREE;
    end else begin
      done         <= 1'b0;
      c0_req_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            base_q         <= base_addr;
            len_q          <= num_lines;
            issue_cnt      <= '0;
            deliver_cnt    <= '0;
            err_unexpected <= 1'b0;
            if (num_lines == '0) done  <= 1'b1;
            else                 state <= S_RUN;
          end
        end
        default: begin
          if (do_issue) begin
            c0_req_valid        <= 1'b1;
            c0_req_addr         <= base_q + 42'(issue_cnt);
            c0_req_mdata        <= 16'(issue_slot);
            slot_st[issue_slot] <= SLOT_PENDING;
            issue_cnt           <= issue_cnt + LEN_W'(1);
          end
          if (do_deliver) begin
            slot_st[deliver_slot] <= SLOT_FREE;
            deliver_cnt           <= deliver_cnt + LEN_W'(1);
            if (last_deliver) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
      endcase

      if (rsp_fill) slot_st[rsp_slot] <= SLOT_FILLED;
      // Placed after the start clear so a stray response in the start cycle still flags.
      if (rsp_bad) err_unexpected <= 1'b1;
    end
  end

  // NOTE: the line buffer is deliberately not reset; a slot is only read once its
  // reset-cleared state says FILLED, and out_data is gated to zero otherwise.
  always_ff @(posedge clk) begin
    if (rsp_fill) slot_data[rsp_slot] <= c0_rsp_data;
  end

endmodule
